// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: mem_ctrl bit layout, size/lr codes, exception codes, FSM states.
// Building with MEM_UNALIGNED_LR_EN makes the lr field (LWL/LWR/SWL/SWR) take effect.
package mem_stage_pkg;

    localparam int CTRL_RD      = 0;
    localparam int CTRL_WR      = 1;
    localparam int CTRL_SIZE_LO = 2;
    localparam int CTRL_UNS     = 4;
    localparam int CTRL_LR_LO   = 5;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [2:0] LR_NONE = 3'd0;
    localparam logic [2:0] LR_LWL  = 3'd1;
    localparam logic [2:0] LR_LWR  = 3'd2;
    localparam logic [2:0] LR_SWL  = 3'd3;
    localparam logic [2:0] LR_SWR  = 3'd4;

    localparam logic [5:0] LS132R_EX_ADEL = 6'h04;
    localparam logic [5:0] LS132R_EX_ADES = 6'h05;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_CANCEL = 3'd4;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] size;
        logic       uns;
        logic [2:0] lr;
    } mem_op_t;

    // Partial-word ops are exempt; a reserved size code is checked like a word.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lr,
                                        input logic [1:0] low);
        if (lr != LR_NONE) begin
            misaligned = 1'b0;
        end else begin
            case (size)
                SIZE_B:  misaligned = 1'b0;
                SIZE_H:  misaligned = low[0];
                default: misaligned = |low;
            endcase
        end
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobe/data placement and load extract/extend (plus LWL/LWR/SWL/SWR
// merging when MEM_UNALIGNED_LR_EN is defined).
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [2:0]  lr,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rvalue
);

    logic [3:0]  st_strb_s;
    logic [31:0] st_data_s;
    logic [31:0] ld_data_s;
    logic [31:0] shifted_s;
    logic [4:0]  sh_s;
    logic [4:0]  sh_inv_s;

    assign sh_s      = {a, 3'b000};
    assign sh_inv_s  = {~a, 3'b000};
    assign shifted_s = rdata >> sh_s;

    // Naturally sized store: replicate data across lanes, strobe the addressed ones.
    always_comb begin
        case (size)
            SIZE_B: begin
                st_strb_s = 4'b0001 << a;
                st_data_s = {4{rt[7:0]}};
            end
            SIZE_H: begin
                st_strb_s = 4'b0011 << a;
                st_data_s = {2{rt[15:0]}};
            end
            default: begin
                st_strb_s = 4'b1111;
                st_data_s = rt;
            end
        endcase
    end

    // Naturally sized load: pick lane, then sign- or zero-extend.
    always_comb begin
        case (size)
            SIZE_B:  ld_data_s = {{24{~uns & shifted_s[7]}}, shifted_s[7:0]};
            SIZE_H:  ld_data_s = {{16{~uns & shifted_s[15]}}, shifted_s[15:0]};
            default: ld_data_s = rdata;
        endcase
    end

`ifdef MEM_UNALIGNED_LR_EN
    // Little-endian MIPS32 partial-word merges override the natural-size result.
    always_comb begin
        wstrb  = st_strb_s;
        wdata  = st_data_s;
        rvalue = ld_data_s;
        case (lr)
            LR_LWL: rvalue = (rdata << sh_inv_s) | (rt & (32'h00ffffff >> sh_s));
            LR_LWR: rvalue = shifted_s | (rt & ~(32'hffffffff >> sh_s));
            LR_SWL: begin
                wstrb = 4'b1111 >> (~a);
                wdata = rt >> sh_inv_s;
            end
            LR_SWR: begin
                wstrb = 4'b1111 << a;
                wdata = rt << sh_s;
            end
            default: begin
                wstrb  = st_strb_s;
                wdata  = st_data_s;
                rvalue = ld_data_s;
            end
        endcase
    end
`else
    logic lr_unused_s;
    logic sh_unused_s;
    assign lr_unused_s = ^lr;
    assign sh_unused_s = ^sh_inv_s;
    assign wstrb  = st_strb_s;
    assign wdata  = st_data_s;
    assign rvalue = ld_data_s;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-SRAM req/addr_ok/data_ok access, address-error detection and the ME->WB
// register. Define MEM_UNALIGNED_LR_EN to honour the lr field of ex_mem_ctrl.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int          EXC_W    = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   int_exc,
    input  logic                   ex_to_me_valid,
    input  logic                   wb_allowin,
    input  logic [31:0]            ex_pc,
    input  logic [31:0]            ex_inst,
    input  logic [10:0]            ex_mem_ctrl,
    input  logic [11:0]            ex_wb_ctrl,
    input  logic [4:0]             ex_waddr,
    input  logic [31:0]            ex_address,
    input  logic [31:0]            ex_write_data,
    input  logic [EXC_W-1:0]       ex_exc,
    input  logic [EXC_W*6-1:0]     ex_excode,
    output logic                   data_req,
    output logic                   data_wr,
    output logic [1:0]             data_size,
    output logic [31:0]            data_addr,
    output logic [3:0]             data_wstrb,
    output logic [31:0]            data_wdata,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    input  logic [31:0]            data_rdata,
    output logic                   me_allowin,
    output logic                   me_to_wb_valid,
    output logic                   me_ex_stall,
    output logic [31:0]            me_pc_o,
    output logic [31:0]            me_inst_o,
    output logic [11:0]            me_wb_ctrl_o,
    output logic [4:0]             me_waddr_o,
    output logic [31:0]            me_result_o,
    output logic [EXC_W:0]         me_exc_o,
    output logic [(EXC_W+1)*6-1:0] me_excode_o,
    output logic [31:0]            me_badvaddr_o
);

    logic [2:0]             state_r;
    logic [2:0]             state_nxt_s;
    logic                   me_valid_r;
    mem_op_t                op_r;
    mem_op_t                op_s;
    logic [31:0]            pc_r;
    logic [31:0]            inst_r;
    logic [11:0]            wb_ctrl_r;
    logic [4:0]             waddr_r;
    logic [31:0]            address_r;
    logic [31:0]            rt_r;
    logic [31:0]            result_r;
    logic [EXC_W:0]         exc_r;
    logic [(EXC_W+1)*6-1:0] excode_r;
    logic [31:0]            badvaddr_r;

    logic                   adexc_s;
    logic                   access_s;
    logic                   accept_s;
    logic                   ready_go_s;
    logic                   leave_s;
    logic                   rdata_hit_s;
    logic [5:0]             adcode_s;
    logic [3:0]             strb_s;
    logic [31:0]            wdata_s;
    logic [31:0]            load_value_s;
    logic                   ctrl_unused_s;

    assign ctrl_unused_s = ^ex_mem_ctrl[10:5];

    // Decode the incoming mem_ctrl word.
    always_comb begin
        op_s.rd   = ex_mem_ctrl[CTRL_RD];
        op_s.wr   = ex_mem_ctrl[CTRL_WR];
        op_s.size = ex_mem_ctrl[CTRL_SIZE_LO +: 2];
        op_s.uns  = ex_mem_ctrl[CTRL_UNS];
`ifdef MEM_UNALIGNED_LR_EN
        if (ex_mem_ctrl[CTRL_LR_LO +: 3] > LR_SWR) begin
            op_s.lr = LR_NONE;
        end else begin
            op_s.lr = ex_mem_ctrl[CTRL_LR_LO +: 3];
        end
`else
        op_s.lr   = LR_NONE;
`endif
    end

    assign adexc_s  = (op_s.rd | op_s.wr) & misaligned(op_s.size, op_s.lr, ex_address[1:0]);
    assign access_s = (op_s.rd | op_s.wr) & ~adexc_s & ~(|ex_exc);
    assign adcode_s = adexc_s ? (op_s.rd ? LS132R_EX_ADEL : LS132R_EX_ADES) : 6'h00;

    assign ready_go_s     = (state_r == ST_IDLE) | (state_r == ST_DONE);
    assign me_allowin     = (state_r != ST_CANCEL) & (~me_valid_r | (ready_go_s & wb_allowin));
    assign me_to_wb_valid = me_valid_r & ready_go_s;
    assign leave_s        = me_to_wb_valid & wb_allowin;
    assign accept_s       = ex_to_me_valid & me_allowin & ~int_exc;
    assign me_ex_stall    = me_valid_r & op_r.rd & ((state_r == ST_REQ) | (state_r == ST_WAIT));
    assign rdata_hit_s    = ((state_r == ST_REQ) & data_addr_ok & data_data_ok) |
                            ((state_r == ST_WAIT) & data_data_ok);

    // Access FSM next state; a flush abandons the access but must still swallow an owed data_ok.
    always_comb begin
        state_nxt_s = state_r;
        if (int_exc) begin
            case (state_r)
                ST_REQ:    state_nxt_s = (data_addr_ok & ~data_data_ok) ? ST_CANCEL : ST_IDLE;
                ST_WAIT:   state_nxt_s = data_data_ok ? ST_IDLE : ST_CANCEL;
                ST_CANCEL: state_nxt_s = data_data_ok ? ST_IDLE : ST_CANCEL;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = (accept_s & access_s) ? ST_REQ : ST_IDLE;
                ST_REQ: begin
                    if (data_addr_ok) begin
                        state_nxt_s = data_data_ok ? ST_DONE : ST_WAIT;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_WAIT:   state_nxt_s = data_data_ok ? ST_DONE : ST_WAIT;
                ST_DONE: begin
                    if (leave_s) begin
                        state_nxt_s = (accept_s & access_s) ? ST_REQ : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                ST_CANCEL: state_nxt_s = data_data_ok ? ST_IDLE : ST_CANCEL;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ME->WB pipeline register; load data overwrites the address-valued result when it returns.
    always_ff @(posedge clk) begin
        if (!resetn || int_exc) begin
            me_valid_r <= 1'b0;
            op_r       <= '0;
            pc_r       <= RESET_PC;
            inst_r     <= 32'd0;
            wb_ctrl_r  <= 12'd0;
            waddr_r    <= 5'd0;
            address_r  <= 32'd0;
            rt_r       <= 32'd0;
            result_r   <= 32'd0;
            exc_r      <= '0;
            excode_r   <= '0;
            badvaddr_r <= 32'd0;
        end else if (accept_s) begin
            me_valid_r <= 1'b1;
            op_r       <= op_s;
            pc_r       <= ex_pc;
            inst_r     <= ex_inst;
            wb_ctrl_r  <= ex_wb_ctrl;
            waddr_r    <= ex_waddr;
            address_r  <= ex_address;
            rt_r       <= ex_write_data;
            result_r   <= ex_address;
            exc_r      <= {adexc_s, ex_exc};
            excode_r   <= {adcode_s, ex_excode};
            badvaddr_r <= adexc_s ? ex_address : 32'd0;
        end else begin
            if (leave_s) begin
                me_valid_r <= 1'b0;
            end
            if (rdata_hit_s && op_r.rd) begin
                result_r <= load_value_s;
            end
        end
    end

    mem_align u_align (
        .a      (address_r[1:0]),
        .size   (op_r.size),
        .uns    (op_r.uns),
        .lr     (op_r.lr),
        .rt     (rt_r),
        .rdata  (data_rdata),
        .wstrb  (strb_s),
        .wdata  (wdata_s),
        .rvalue (load_value_s)
    );

    // Bus outputs are quiet (zero) whenever no request is outstanding.
    assign data_req   = (state_r == ST_REQ);
    assign data_wr    = data_req & op_r.wr;
    assign data_size  = !data_req ? 2'd0 : ((op_r.lr != LR_NONE) ? SIZE_W : op_r.size);
    assign data_addr  = !data_req ? 32'd0 :
                        ((op_r.lr != LR_NONE) ? {address_r[31:2], 2'b00} : address_r);
    assign data_wstrb = data_wr ? strb_s : 4'b0000;
    assign data_wdata = data_wr ? wdata_s : 32'd0;

    assign me_pc_o       = pc_r;
    assign me_inst_o     = inst_r;
    assign me_wb_ctrl_o  = wb_ctrl_r;
    assign me_waddr_o    = waddr_r;
    assign me_result_o   = result_r;
    assign me_exc_o      = exc_r;
    assign me_excode_o   = excode_r;
    assign me_badvaddr_o = badvaddr_r;

endmodule
